// File: rtl/lsu_dccm_stbuf.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_dccm_stbuf
//  Purpose  : Store buffer in front of the DCCM write port. It accepts
//             ECC-encoded store words from the LSU and drains them in order
//             into the DCCM. It gives the DCCM to loads except when the
//             buffer is full, and it flags a load that overlaps any pending
//             store so the LSU can replay that load.
//  Ports    : clk, rst                      - clock, synchronous active-high reset
//             st_valid/st_ready/st_addr/st_data - store push handshake
//             freeze                        - stalls draining (push still allowed)
//             rd_req/rd_addr_lo/rd_addr_hi  - load request and its two word addresses
//             rd_grant/rd_hazard            - load may read / load must replay
//             dccm_wren/dccm_wr_addr/dccm_wr_data - DCCM write port
//             empty                         - no pending stores
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_dccm_stbuf #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 39,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic              freeze,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr_lo,
    input  logic [ADDR_W-1:0] rd_addr_hi,
    output logic              rd_grant,
    output logic              rd_hazard,
    output logic              dccm_wren,
    output logic [ADDR_W-1:0] dccm_wr_addr,
    output logic [DATA_W-1:0] dccm_wr_data,
    output logic              empty
);

    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_DEPTH = (PTR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_drain;
    logic              w_hit_lo;
    logic              w_hit_hi;
    logic [DEPTH-1:0]  w_valid;

    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);

    // Outputs are forced to their idle values while rst is high so a reset
    // arriving mid-drain never produces a partial DCCM write.
    assign w_push  = ~rst & st_valid & ~w_full;
    assign w_drain = ~rst & ~w_empty & ~freeze & (~rd_req | w_full);

    assign st_ready     = rst | ~w_full;
    assign empty        = rst | w_empty;
    assign dccm_wren    = w_drain;
    assign dccm_wr_addr = w_empty ? '0 : r_addr[r_rd_ptr];
    assign dccm_wr_data = w_empty ? '0 : r_data[r_rd_ptr];

    // Word-granular hazard compare against every occupied slot (including
    // the head that may be draining this cycle) and the store being pushed.
    // A slot is occupied when its distance from rd_ptr is below count.
    always_comb begin
        w_valid  = '0;
        w_hit_lo = w_push & (st_addr[ADDR_W-1:2] == rd_addr_lo[ADDR_W-1:2]);
        w_hit_hi = w_push & (st_addr[ADDR_W-1:2] == rd_addr_hi[ADDR_W-1:2]);
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i] = ({1'b0, PTR_W'(i) - r_rd_ptr} < r_count);
            if (w_valid[i] && (r_addr[i][ADDR_W-1:2] == rd_addr_lo[ADDR_W-1:2]))
                w_hit_lo = 1'b1;
            if (w_valid[i] && (r_addr[i][ADDR_W-1:2] == rd_addr_hi[ADDR_W-1:2]))
                w_hit_hi = 1'b1;
        end
    end

    assign rd_hazard = ~rst & rd_req & (w_hit_lo | w_hit_hi);
    assign rd_grant  = rd_req & ~rd_hazard & ~w_drain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_drain)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_drain})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: unoccupied slots are masked by w_valid and
    // the write-port outputs are zeroed while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= st_addr;
            r_data[r_wr_ptr] <= st_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_dccm_stbuf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_dccm_stbuf
//  Purpose  : Self-checking bench for lsu_dccm_stbuf. A queue-based model of
//             the pending stores predicts the handshake and hazard outputs
//             every cycle; each accepted store is pushed to a scoreboard
//             queue that a separate monitor pops on every DCCM write.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_dccm_stbuf;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 39;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              freeze;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr_lo;
    logic [ADDR_W-1:0] rd_addr_hi;
    logic              rd_grant;
    logic              rd_hazard;
    logic              dccm_wren;
    logic [ADDR_W-1:0] dccm_wr_addr;
    logic [DATA_W-1:0] dccm_wr_data;
    logic              empty;

    int total = 0;
    int bad   = 0;

    // Model: addresses of pending stores, oldest first.
    logic [ADDR_W-1:0]        mq [$];
    // Scoreboard: expected DCCM writes {addr, data}, oldest first.
    logic [ADDR_W+DATA_W-1:0] eq [$];

    lsu_dccm_stbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .freeze       (freeze),
        .rd_req       (rd_req),
        .rd_addr_lo   (rd_addr_lo),
        .rd_addr_hi   (rd_addr_hi),
        .rd_grant     (rd_grant),
        .rd_hazard    (rd_hazard),
        .dccm_wren    (dccm_wren),
        .dccm_wr_addr (dccm_wr_addr),
        .dccm_wr_data (dccm_wr_data),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: evaluated mid-cycle, then advanced to the next cycle.
    always @(negedge clk) begin
        logic e_empty, e_full, e_acc, e_drain, e_hz, e_grant;
        if (rst) begin
            chk("rst_ready", st_ready, 1);
            chk("rst_empty", empty, 1);
            chk("rst_wren", dccm_wren, 0);
            chk("rst_hazard", rd_hazard, 0);
            chk("rst_grant", rd_grant, rd_req);
            mq.delete();
            eq.delete();
        end else begin
            e_empty = (mq.size() == 0);
            e_full  = (mq.size() == DEPTH);
            e_acc   = st_valid && !e_full;
            e_drain = !e_empty && !freeze && (!rd_req || e_full);
            e_hz    = 1'b0;
            foreach (mq[k])
                if (mq[k] / 4 == rd_addr_lo / 4 || mq[k] / 4 == rd_addr_hi / 4) e_hz = 1'b1;
            if (e_acc && (st_addr / 4 == rd_addr_lo / 4 || st_addr / 4 == rd_addr_hi / 4)) e_hz = 1'b1;
            e_hz    = e_hz && rd_req;
            e_grant = rd_req && !e_hz && !e_drain;
            chk("st_ready", st_ready, !e_full);
            chk("empty", empty, e_empty);
            chk("wren", dccm_wren, e_drain);
            chk("hazard", rd_hazard, e_hz);
            chk("grant", rd_grant, e_grant);
            if (e_empty) begin
                chk("idle_addr", dccm_wr_addr, 0);
                chk("idle_data", dccm_wr_data, 0);
            end
            if (e_drain) void'(mq.pop_front());
            if (e_acc) begin
                mq.push_back(st_addr);
                eq.push_back({st_addr, st_data});
            end
        end
    end

    // Monitor: every DCCM write must match the oldest accepted store.
    always @(negedge clk) begin
        logic [ADDR_W+DATA_W-1:0] e;
        if (dccm_wren) begin
            if (eq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_unexpected: got write addr %h expected none at %0t", dccm_wr_addr, $time);
            end else begin
                e = eq.pop_front();
                chk("wr_addr", dccm_wr_addr, e[ADDR_W+DATA_W-1:DATA_W]);
                chk("wr_data", dccm_wr_data, e[DATA_W-1:0]);
            end
        end
    end

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        return v[DATA_W-1:0];
    endfunction

    task automatic drive(input logic v, input logic [ADDR_W-1:0] a, input logic rq,
                         input logic [ADDR_W-1:0] lo, input logic [ADDR_W-1:0] hi,
                         input logic fz);
        st_valid   = v;
        st_addr    = a;
        st_data    = rnd_data();
        rd_req     = rq;
        rd_addr_lo = lo;
        rd_addr_hi = hi;
        freeze     = fz;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 16'h0, 0, 16'h0, 16'h0, 0);
    endtask

    initial begin
        logic done;
        rst = 1'b1;
        drive(0, 16'h0, 1, 16'h0F00, 16'h0F04, 0);
        drive(1, 16'h0010, 0, 16'h0, 16'h0, 0);
        rst = 1'b0;

        // In-order drain of three stores with no load traffic.
        drive(1, 16'h0100, 0, 16'h0, 16'h0, 0);
        drive(1, 16'h0104, 0, 16'h0, 16'h0, 0);
        drive(1, 16'h0108, 0, 16'h0, 16'h0, 0);
        idle(3);

        // Fill with a load held, forced drain, then the fifth store.
        for (int i = 0; i < 4; i++) drive(1, 16'(16'h0400 + 4 * i), 1, 16'h0F00, 16'h0F04, 0);
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            done = (mq.size() < DEPTH);
            drive(1, 16'h0410, 1, 16'h0F00, 16'h0F04, 0);
        end
        drive(0, 16'h0, 1, 16'h0F00, 16'h0F04, 0);
        idle(6);

        // Pending store vs. overlapping and adjacent loads.
        drive(1, 16'h0200, 1, 16'h0800, 16'h0804, 0);
        drive(0, 16'h0, 1, 16'h0202, 16'h0800, 0);
        drive(0, 16'h0, 1, 16'h0204, 16'h0208, 0);
        idle(2);

        // Incoming store hits the load's high word on an empty buffer.
        drive(1, 16'h0300, 1, 16'h0500, 16'h0300, 0);
        idle(2);

        // Freeze with two entries, then release.
        drive(1, 16'h0600, 0, 16'h0, 16'h0, 1);
        drive(1, 16'h0604, 0, 16'h0, 16'h0, 1);
        drive(0, 16'h0, 0, 16'h0, 16'h0, 1);
        drive(0, 16'h0, 1, 16'h0600, 16'h0700, 1);
        idle(3);

        // Continuous traffic across pointer wrap, then reset with entries pending.
        for (int i = 0; i < 10; i++) drive(1, 16'(16'h0700 + 4 * i), 0, 16'h0, 16'h0, 0);
        for (int i = 0; i < 3; i++) drive(1, 16'(16'h0780 + 4 * i), 1, 16'h0F00, 16'h0F04, 0);
        rst = 1'b1;
        drive(1, 16'h0790, 0, 16'h0, 16'h0, 0);
        drive(0, 16'h0, 1, 16'h0780, 16'h0784, 0);
        rst = 1'b0;
        idle(4);

        // Randomized traffic over a small address window to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 99) < 60,
                  16'(16'h0A00 + $urandom_range(0, 31)),
                  $urandom_range(0, 99) < 50,
                  16'(16'h0A00 + $urandom_range(0, 31)),
                  16'(16'h0A00 + $urandom_range(0, 31)),
                  $urandom_range(0, 99) < 10);
        end
        rst = 1'b0;
        idle(8);
        chk("drain_left", 64'(eq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
